// File: rtl/psram_mem_ctrl_if.sv
// Bus-side handshake between the 6510 address/data bus and the PSRAM controller.
interface psram_mem_ctrl_if;
  logic        CE;
  logic        write;
  logic [5:0]  bank;
  logic [15:0] addrBus;
  logic [7:0]  dataToWrite;
  logic [7:0]  dataRead;
  logic        busy;

  modport master (
    output CE, write, bank, addrBus, dataToWrite,
    input  dataRead, busy
  );

  modport slave (
    input  CE, write, bank, addrBus, dataToWrite,
    output dataRead, busy
  );
endinterface

// File: rtl/psram_mem_ctrl.sv
// Byte-wide controller for two QSPI PSRAM chips run in QPI mode side by side.
// Chip A sits on io 3:0 and chip B on io 7:4; both receive identical traffic,
// read data is taken from chip A only.
module psram_mem_ctrl #(
  parameter int INIT_DELAY = 7500,
  parameter int READ_WAIT  = 7
) (
  input  logic             clk,
  input  logic             reset,
  psram_mem_ctrl_if.slave  bus,
  inout  wire              io_psram_data0,
  inout  wire              io_psram_data1,
  inout  wire              io_psram_data2,
  inout  wire              io_psram_data3,
  inout  wire              io_psram_data4,
  inout  wire              io_psram_data5,
  inout  wire              io_psram_data6,
  inout  wire              io_psram_data7,
  output logic             o_psram_cs,
  output logic             o_psram_sclk,
  output logic [7:0]       debug
);

  localparam int CNT_W = $clog2(INIT_DELAY + READ_WAIT + 16);

  localparam logic [4:0] INIT_1     = 5'd0;
  localparam logic [4:0] INIT_2     = 5'd1;
  localparam logic [4:0] ENABLE_QPI = 5'd2;
  localparam logic [4:0] IDLE       = 5'd3;
  localparam logic [4:0] CMD_1      = 5'd4;
  localparam logic [4:0] CMD_8      = 5'd11;
  localparam logic [4:0] ADDR_19_16 = 5'd12;
  localparam logic [4:0] ADDR_15_12 = 5'd13;
  localparam logic [4:0] ADDR_11_8  = 5'd14;
  localparam logic [4:0] ADDR_7_4   = 5'd15;
  localparam logic [4:0] ADDR_3_0   = 5'd16;
  localparam logic [4:0] DATA_7_4   = 5'd17;
  localparam logic [4:0] DATA_3_0   = 5'd18;
  localparam logic [4:0] WAIT       = 5'd19;
  localparam logic [4:0] READ_7_4   = 5'd20;
  localparam logic [4:0] READ_3_0   = 5'd21;

  localparam logic [7:0] QPI_CMD   = 8'h35;
  localparam logic [7:0] WRITE_CMD = 8'h38;
  localparam logic [7:0] READ_CMD  = 8'hEB;

  logic [4:0]       state, nState;
  logic [CNT_W-1:0] cnt, nCnt;
  logic             wrReg, nWrite;
  logic [19:0]      addrReg, nAddr;
  logic [7:0]       dataReg, nData;
  logic             csReg, nCs;
  logic [7:0]       oeReg, nOe;
  logic [7:0]       outReg, nOut;
  logic [3:0]       hiNib;
  logic [7:0]       dataReadReg;
  logic             ceLast;
  logic             request;
  logic [4:0]       cmdIdx;
  logic [7:0]       cmdByte;
  logic [3:0]       nib;
  logic [3:0]       ioA;
  logic             unusedBits;

  assign ioA        = {io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};
  assign unusedBits = ^bus.bank[5:4];
  assign request    = bus.CE & ~ceLast & (state == IDLE);

  // Next state, counter and transaction latch, plus the pin values for the next state
  always_comb begin
    nState = state;
    nCnt   = cnt;
    nWrite = wrReg;
    nAddr  = addrReg;
    nData  = dataReg;
    case (state) inside
      INIT_1: begin
        if (cnt <= CNT_W'(1)) begin
          nState = INIT_2;
          nCnt   = '0;
        end else begin
          nCnt = cnt - CNT_W'(1);
        end
      end
      INIT_2: begin
        nState = ENABLE_QPI;
        nCnt   = '0;
      end
      ENABLE_QPI: begin
        if (cnt == CNT_W'(7)) nState = IDLE;
        else                  nCnt   = cnt + CNT_W'(1);
      end
      IDLE: begin
        if (request) begin
          nState = CMD_1;
          nWrite = bus.write;
          nAddr  = {bus.bank[3:0], bus.addrBus};
          nData  = bus.dataToWrite;
        end
      end
      ADDR_3_0: begin
        nState = nWrite ? DATA_7_4 : WAIT;
        nCnt   = CNT_W'(1);
      end
      WAIT: begin
        if (cnt >= CNT_W'(READ_WAIT)) nState = READ_7_4;
        else                          nCnt   = cnt + CNT_W'(1);
      end
      DATA_3_0, READ_3_0: nState = IDLE;
      [CMD_1:CMD_8], [ADDR_19_16:ADDR_7_4], DATA_7_4, READ_7_4: nState = state + 5'd1;
      default: nState = INIT_1;
    endcase

    cmdByte = nWrite ? WRITE_CMD : READ_CMD;
    cmdIdx  = CMD_8 - nState;
    case (nState)
      ADDR_19_16: nib = nAddr[19:16];
      ADDR_15_12: nib = nAddr[15:12];
      ADDR_11_8:  nib = nAddr[11:8];
      ADDR_7_4:   nib = nAddr[7:4];
      ADDR_3_0:   nib = nAddr[3:0];
      DATA_7_4:   nib = nData[7:4];
      default:    nib = nData[3:0];
    endcase

    nCs  = 1'b1;
    nOe  = 8'h00;
    nOut = 8'h00;
    if (nState == ENABLE_QPI) begin
      nCs  = 1'b0;
      nOe  = 8'h11;
      nOut = {8{QPI_CMD[3'd7 - nCnt[2:0]]}};
    end else if (nState >= CMD_1 && nState <= CMD_8) begin
      nCs  = 1'b0;
      nOe  = 8'h11;
      nOut = {8{cmdByte[cmdIdx[2:0]]}};
    end else if (nState >= ADDR_19_16 && nState <= DATA_3_0) begin
      nCs  = 1'b0;
      nOe  = 8'hFF;
      nOut = {nib, nib};
    end else if (nState >= WAIT && nState <= READ_3_0) begin
      nCs = 1'b0;
    end
  end

  // Control state, chip select and lane enables; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT_1;
      cnt         <= CNT_W'(INIT_DELAY);
      csReg       <= 1'b1;
      oeReg       <= 8'h00;
      dataReadReg <= 8'h00;
    end else begin
      state <= nState;
      cnt   <= nCnt;
      csReg <= nCs;
      oeReg <= nOe;
      if (state == READ_3_0) dataReadReg <= {hiNib, ioA};
    end
  end

  // Datapath registers: latched request, lane values, upper read nibble, CE history
  always_ff @(posedge clk) begin
    wrReg   <= nWrite;
    addrReg <= nAddr;
    dataReg <= nData;
    outReg  <= nOut;
    ceLast  <= bus.CE;
    if (state == READ_7_4) hiNib <= ioA;
  end

  assign io_psram_data0 = oeReg[0] ? outReg[0] : 1'bz;
  assign io_psram_data1 = oeReg[1] ? outReg[1] : 1'bz;
  assign io_psram_data2 = oeReg[2] ? outReg[2] : 1'bz;
  assign io_psram_data3 = oeReg[3] ? outReg[3] : 1'bz;
  assign io_psram_data4 = oeReg[4] ? outReg[4] : 1'bz;
  assign io_psram_data5 = oeReg[5] ? outReg[5] : 1'bz;
  assign io_psram_data6 = oeReg[6] ? outReg[6] : 1'bz;
  assign io_psram_data7 = oeReg[7] ? outReg[7] : 1'bz;

  // PSRAM samples mid-bit: its clock is the inverted system clock while selected
  assign o_psram_sclk = ~csReg & ~clk;
  assign o_psram_cs   = csReg;
  assign debug        = {3'b000, state};
  assign bus.dataRead = dataReadReg;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_psram_mem_ctrl.sv
// Directed bench for psram_mem_ctrl: init/QPI enable, write, read, CE retrigger, reset abort.
module tb_psram_mem_ctrl;

  localparam int INIT_DELAY = 20;
  localparam int READ_WAIT  = 7;

  logic clk = 1'b0;
  logic reset;
  wire  io0, io1, io2, io3, io4, io5, io6, io7;
  logic cs, sclk;
  logic [7:0] debug;
  logic tbDrv;
  logic [3:0] tbNib;

  int nChecks = 0;
  int nErrors = 0;

  psram_mem_ctrl_if bus ();

  psram_mem_ctrl #(.INIT_DELAY(INIT_DELAY), .READ_WAIT(READ_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .io_psram_data0(io0), .io_psram_data1(io1), .io_psram_data2(io2), .io_psram_data3(io3),
    .io_psram_data4(io4), .io_psram_data5(io5), .io_psram_data6(io6), .io_psram_data7(io7),
    .o_psram_cs(cs), .o_psram_sclk(sclk), .debug(debug)
  );

  // Chip A model: drives read data only when asked
  assign io0 = tbDrv ? tbNib[0] : 1'bz;
  assign io1 = tbDrv ? tbNib[1] : 1'bz;
  assign io2 = tbDrv ? tbNib[2] : 1'bz;
  assign io3 = tbDrv ? tbNib[3] : 1'bz;

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction: CE low then high, then record pins while cs is low
  task automatic doTxn(input string tag, input logic wr, input logic [5:0] bank,
                       input logic [15:0] addr, input logic [7:0] data,
                       input logic [7:0] expCmd, input logic [19:0] expAddr,
                       input logic [7:0] rdData, input int expLen);
    logic [7:0]  cmdA, cmdB, wdA, wdB;
    logic [19:0] adA, adB;
    int n;
    cmdA = 0; cmdB = 0; wdA = 0; wdB = 0; adA = 0; adB = 0;
    bus.CE = 1'b0;
    tick();
    bus.CE = 1'b1; bus.write = wr; bus.bank = bank; bus.addrBus = addr; bus.dataToWrite = data;
    tick();
    checkVal({tag, "_busyStart"}, {31'b0, bus.busy}, 32'd1);
    checkVal({tag, "_sclkLow"}, {31'b0, sclk}, 32'd1);
    n = 0;
    while (cs == 1'b0 && n < 40) begin
      if (n < 8) begin
        cmdA = {cmdA[6:0], io0};
        cmdB = {cmdB[6:0], io4};
      end else if (n < 13) begin
        adA = {adA[15:0], io3, io2, io1, io0};
        adB = {adB[15:0], io7, io6, io5, io4};
      end else if (wr && n < 15) begin
        wdA = {wdA[3:0], io3, io2, io1, io0};
        wdB = {wdB[3:0], io7, io6, io5, io4};
      end
      tbDrv = !wr && (n == 20 || n == 21);
      tbNib = (n == 20) ? rdData[7:4] : rdData[3:0];
      tick();
      n++;
    end
    tbDrv = 1'b0;
    checkVal({tag, "_len"}, n, expLen);
    checkVal({tag, "_cmdA"}, {24'b0, cmdA}, {24'b0, expCmd});
    checkVal({tag, "_cmdB"}, {24'b0, cmdB}, {24'b0, expCmd});
    checkVal({tag, "_addrA"}, {12'b0, adA}, {12'b0, expAddr});
    checkVal({tag, "_addrB"}, {12'b0, adB}, {12'b0, expAddr});
    if (wr) begin
      checkVal({tag, "_dataA"}, {24'b0, wdA}, {24'b0, data});
      checkVal({tag, "_dataB"}, {24'b0, wdB}, {24'b0, data});
    end
    checkVal({tag, "_busyEnd"}, {31'b0, bus.busy}, 32'd0);
    checkVal({tag, "_csEnd"}, {31'b0, cs}, 32'd1);
    checkVal({tag, "_sclkIdle"}, {31'b0, sclk}, 32'd0);
  endtask

  initial begin
    logic [7:0] q0, q4;
    reset = 1'b1;
    tbDrv = 1'b0; tbNib = 4'h0;
    bus.CE = 1'b0; bus.write = 1'b0; bus.bank = 6'h0; bus.addrBus = 16'h0; bus.dataToWrite = 8'h0;
    repeat (3) tick();
    checkVal("rst_busy", {31'b0, bus.busy}, 32'd1);
    checkVal("rst_cs", {31'b0, cs}, 32'd1);
    checkVal("rst_state", {24'b0, debug}, 32'd0);
    checkVal("rst_dataRead", {24'b0, bus.dataRead}, 32'h00);

    // Init delay, INIT_2, QPI enable
    reset = 1'b0;
    repeat (INIT_DELAY - 1) tick();
    checkVal("init1_hold", {24'b0, debug}, 32'd0);
    tick();
    checkVal("init2", {24'b0, debug}, 32'd1);
    checkVal("init2_cs", {31'b0, cs}, 32'd1);
    tick();
    checkVal("qpi_state", {24'b0, debug}, 32'd2);
    q0 = 0; q4 = 0;
    for (int i = 0; i < 8; i++) begin
      checkVal("qpi_cs", {31'b0, cs}, 32'd0);
      q0 = {q0[6:0], io0};
      q4 = {q4[6:0], io4};
      tick();
    end
    checkVal("qpi_io0", {24'b0, q0}, 32'h35);
    checkVal("qpi_io4", {24'b0, q4}, 32'h35);
    checkVal("idle_state", {24'b0, debug}, 32'd3);
    checkVal("idle_busy", {31'b0, bus.busy}, 32'd0);
    checkVal("idle_cs", {31'b0, cs}, 32'd1);

    doTxn("wr1", 1'b1, 6'h00, 16'hC000, 8'hAA, 8'h38, 20'h0C000, 8'h00, 15);

    // CE held high: no retrigger
    repeat (3) tick();
    checkVal("hold_busy", {31'b0, bus.busy}, 32'd0);
    checkVal("hold_cs", {31'b0, cs}, 32'd1);
    checkVal("hold_state", {24'b0, debug}, 32'd3);

    doTxn("rd1", 1'b0, 6'h00, 16'hC000, 8'h00, 8'hEB, 20'h0C000, 8'h5A, 22);
    checkVal("rd1_dataRead", {24'b0, bus.dataRead}, 32'h5A);

    // Bank bits 5:4 ignored; dataRead unchanged by a write
    doTxn("wr2", 1'b1, 6'h35, 16'h1234, 8'h3C, 8'h38, 20'h51234, 8'h00, 15);
    checkVal("wr2_dataRead", {24'b0, bus.dataRead}, 32'h5A);

    doTxn("rd2", 1'b0, 6'h0A, 16'hFFFF, 8'h00, 8'hEB, 20'hAFFFF, 8'hC3, 22);
    checkVal("rd2_dataRead", {24'b0, bus.dataRead}, 32'hC3);

    // Reset during address phase
    bus.CE = 1'b0;
    tick();
    bus.CE = 1'b1; bus.write = 1'b1; bus.bank = 6'h1; bus.addrBus = 16'h0F0F; bus.dataToWrite = 8'h55;
    tick();
    repeat (10) tick();
    checkVal("abort_addrPhase", {24'b0, debug}, 32'd14);
    checkVal("abort_csBefore", {31'b0, cs}, 32'd0);
    reset = 1'b1;
    tick();
    checkVal("abort_cs", {31'b0, cs}, 32'd1);
    checkVal("abort_busy", {31'b0, bus.busy}, 32'd1);
    checkVal("abort_state", {24'b0, debug}, 32'd0);
    reset = 1'b0;
    repeat (INIT_DELAY) tick();
    checkVal("reinit2", {24'b0, debug}, 32'd1);
    repeat (9) tick();
    checkVal("reinit_idle", {24'b0, debug}, 32'd3);
    checkVal("reinit_busy", {31'b0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
